// File: rtl/tag_ctrl_2way.sv
// Lookup/fill sequencer for the two tag RAMs of a 2-way L1 cache.
// Optional power-up tag sweep: define TAG_CLEAR_EN.
module tag_ctrl_2way #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AWIDTH-1:0] req_index,
  input  logic [DWIDTH-2:0] req_tag,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic              rsp_way,
  output logic              fill_req,
  input  logic              fill_ack,
  output logic [AWIDTH-1:0] t0_addr,
  output logic [DWIDTH-1:0] t0_din,
  output logic              t0_we,
  input  logic [DWIDTH-1:0] t0_dout,
  output logic [AWIDTH-1:0] t1_addr,
  output logic [DWIDTH-1:0] t1_din,
  output logic              t1_we,
  input  logic [DWIDTH-1:0] t1_dout
);
  localparam int DEPTH = 1 << AWIDTH;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_MISS   = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
`ifdef TAG_CLEAR_EN
  localparam logic [2:0] S_CLEAR  = 3'd4;
  localparam logic [2:0] S_RESET  = S_CLEAR;
`else
  localparam logic [2:0] S_RESET  = S_IDLE;
`endif

  logic [2:0]        r_state;
  logic [AWIDTH-1:0] r_index;
  logic [DWIDTH-2:0] r_tag;
  logic              r_victim;
  logic [DEPTH-1:0]  r_lru;
  logic              r_rsp_valid;
  logic              r_rsp_hit;
  logic              r_rsp_way;
`ifdef TAG_CLEAR_EN
  logic [AWIDTH-1:0] r_clr_idx;
`endif

  logic [DWIDTH-1:0] w_dout [2];
  logic [1:0]        w_valid;
  logic [1:0]        w_hit;
  logic              w_hit_way;
  logic              w_victim;
  logic [AWIDTH-1:0] w_addr;
  logic [1:0]        w_we;
  logic [DWIDTH-1:0] w_din;

  assign w_dout[0] = t0_dout;
  assign w_dout[1] = t1_dout;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_way
      assign w_valid[gi] = w_dout[gi][DWIDTH-1];
      assign w_hit[gi]   = w_valid[gi] & (w_dout[gi][DWIDTH-2:0] == r_tag);
    end
  endgenerate

  // Way0 wins when both ways hold the tag.
  assign w_hit_way = ~w_hit[0];

  always_comb begin
    w_victim = r_lru[r_index];
    if (!w_valid[0]) begin
      w_victim = 1'b0;
    end else if (!w_valid[1]) begin
      w_victim = 1'b1;
    end
  end

  // The RAMs are addressed straight from the request in IDLE so the read
  // lands in LOOKUP; afterwards the latched index keeps the address stable.
  always_comb begin
    w_addr = r_index;
    w_we   = 2'b00;
    w_din  = '0;
    case (r_state)
      S_IDLE: w_addr = req_index;
      S_WRITE: begin
        w_we[r_victim] = 1'b1;
        w_din          = {1'b1, r_tag};
      end
`ifdef TAG_CLEAR_EN
      S_CLEAR: begin
        w_addr = r_clr_idx;
        w_we   = 2'b11;
      end
`endif
      default: ;
    endcase
    if (reset) begin
      w_addr = '0;
      w_we   = 2'b00;
      w_din  = '0;
    end
  end

  assign t0_addr   = w_addr;
  assign t1_addr   = w_addr;
  assign t0_we     = w_we[0];
  assign t1_we     = w_we[1];
  assign t0_din    = w_din;
  assign t1_din    = w_din;
  assign req_ready = (r_state == S_IDLE);
  assign fill_req  = (r_state == S_MISS) & ~reset;
  assign rsp_valid = r_rsp_valid;
  assign rsp_hit   = r_rsp_hit;
  assign rsp_way   = r_rsp_way;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_RESET;
      r_index     <= '0;
      r_tag       <= '0;
      r_victim    <= 1'b0;
      r_lru       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_way   <= 1'b0;
`ifdef TAG_CLEAR_EN
      r_clr_idx   <= '0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_index <= req_index;
            r_tag   <= req_tag;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (|w_hit) begin
            r_rsp_valid    <= 1'b1;
            r_rsp_hit      <= 1'b1;
            r_rsp_way      <= w_hit_way;
            r_lru[r_index] <= ~w_hit_way;
            r_state        <= S_IDLE;
          end else begin
            r_victim <= w_victim;
            r_state  <= S_MISS;
          end
        end
        S_MISS: begin
          // Response is raised here so it coincides with the tag write cycle.
          if (fill_ack) begin
            r_rsp_valid <= 1'b1;
            r_rsp_hit   <= 1'b0;
            r_rsp_way   <= r_victim;
            r_state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_lru[r_index] <= ~r_victim;
          r_state        <= S_IDLE;
        end
`ifdef TAG_CLEAR_EN
        S_CLEAR: begin
          r_clr_idx <= r_clr_idx + 1'b1;
          if (r_clr_idx == AWIDTH'(DEPTH - 1)) begin
            r_state <= S_IDLE;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tag_ctrl_2way.sv
// Bench for tag_ctrl_2way: behavioural tag RAMs, shadow tag/LRU model and
// response/write scoreboards. Also runs with TAG_CLEAR_EN defined.
module tb_tag_ctrl_2way;
  localparam int AW    = 3;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_index = '0;
  logic [DW-2:0] req_tag = '0;
  logic          rsp_valid, rsp_hit, rsp_way;
  logic          fill_req;
  logic          fill_ack = 1'b0;
  logic [AW-1:0] t0_addr, t1_addr;
  logic [DW-1:0] t0_din, t1_din, t0_dout, t1_dout;
  logic          t0_we, t1_we;

  tag_ctrl_2way #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_index(req_index), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
    .fill_req(fill_req), .fill_ack(fill_ack),
    .t0_addr(t0_addr), .t0_din(t0_din), .t0_we(t0_we), .t0_dout(t0_dout),
    .t1_addr(t1_addr), .t1_din(t1_din), .t1_we(t1_we), .t1_dout(t1_dout)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Tag RAMs with 1-cycle synchronous read, preloaded at time 0.
  logic [DW-1:0] ram0 [DEPTH];
  logic [DW-1:0] ram1 [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram0[i] = '0;
      ram1[i] = '0;
    end
    ram0[2] = 16'h8ABC; ram1[2] = 16'h8DEF;
    ram0[5] = 16'h8011; ram1[5] = 16'h8022;
    ram0[1] = 16'h8005;
    ram0[6] = 16'h8007; ram1[6] = 16'h8007;
    forever begin
      @(posedge clock);
      if (t0_we) ram0[t0_addr] <= t0_din;
      if (t1_we) ram1[t1_addr] <= t1_din;
      t0_dout <= ram0[t0_addr];
      t1_dout <= ram1[t1_addr];
    end
  end

  // Shadow of the tag contents and LRU bits as the bench expects them.
  logic [DW-1:0]    exp0 [DEPTH];
  logic [DW-1:0]    exp1 [DEPTH];
  logic [DEPTH-1:0] mlru;

  typedef struct { logic hit; logic way; int ref_cyc; } rsp_t;
  typedef struct { logic way; logic [AW-1:0] idx; logic [DW-1:0] din; } wr_t;
  rsp_t rsp_q [$];
  wr_t  wr_q  [$];
  rsp_t rsp_e;
  wr_t  wr_e;

  int checks = 0;
  int errors = 0;
  int n_rsp  = 0;
  int n_we   = 0;
  logic clearing = 1'b0;

  always @(negedge clock) begin
    if (!reset && rsp_valid) begin
      n_rsp <= n_rsp + 1;
      checks++;
      if (rsp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got hit=%0b way=%0b exp none", rsp_hit, rsp_way);
      end else begin
        rsp_e = rsp_q.pop_front();
        $display("rsp cyc=%0d hit=%0b way=%0b (exp hit=%0b way=%0b)", cyc, rsp_hit, rsp_way, rsp_e.hit, rsp_e.way);
        if (rsp_hit !== rsp_e.hit || rsp_way !== rsp_e.way) begin
          errors++;
          $display("FAIL rsp_data got hit=%0b way=%0b exp hit=%0b way=%0b", rsp_hit, rsp_way, rsp_e.hit, rsp_e.way);
        end
        if (rsp_e.hit) begin
          checks++;
          if (cyc - rsp_e.ref_cyc !== 1) begin
            errors++;
            $display("FAIL hit_latency got=%0d exp=1", cyc - rsp_e.ref_cyc);
          end
        end
      end
    end
    if (!reset && !clearing && (t0_we || t1_we)) begin
      n_we <= n_we + 1;
      checks++;
      if (wr_q.size() == 0 || (t0_we && t1_we)) begin
        errors++;
        $display("FAIL write_unexpected got we0=%0b we1=%0b din=%h exp no write", t0_we, t1_we, t0_din);
      end else begin
        wr_e = wr_q.pop_front();
        $display("write way=%0b idx=%0d din=%h", t1_we, t1_we ? t1_addr : t0_addr, t1_we ? t1_din : t0_din);
        if (t1_we !== wr_e.way || (t1_we ? t1_addr : t0_addr) !== wr_e.idx ||
            (t1_we ? t1_din : t0_din) !== wr_e.din) begin
          errors++;
          $display("FAIL write_data got way=%0b idx=%0d din=%h exp way=%0b idx=%0d din=%h",
                   t1_we, t1_we ? t1_addr : t0_addr, t1_we ? t1_din : t0_din, wr_e.way, wr_e.idx, wr_e.din);
        end
      end
    end
  end

  task automatic predict(input logic [AW-1:0] idx, input logic [DW-2:0] tag, input int refc, output logic miss);
    logic v0, v1, h0, h1, vic;
    rsp_t r;
    wr_t  w;
    v0 = exp0[idx][DW-1];
    v1 = exp1[idx][DW-1];
    h0 = v0 && (exp0[idx][DW-2:0] == tag);
    h1 = v1 && (exp1[idx][DW-2:0] == tag);
    r.ref_cyc = refc;
    if (h0 || h1) begin
      r.hit = 1'b1;
      r.way = h0 ? 1'b0 : 1'b1;
      mlru[idx] = ~r.way;
    end else begin
      vic = !v0 ? 1'b0 : (!v1 ? 1'b1 : mlru[idx]);
      r.hit = 1'b0;
      r.way = vic;
      w.way = vic;
      w.idx = idx;
      w.din = {1'b1, tag};
      wr_q.push_back(w);
      if (vic) exp1[idx] = w.din;
      else     exp0[idx] = w.din;
      mlru[idx] = ~vic;
    end
    rsp_q.push_back(r);
    miss = !(h0 || h1);
  endtask

  task automatic drain();
    int t = 0;
    #1;
    while (rsp_q.size() != 0 && t < 20) begin
      @(negedge clock); #1;
      t++;
    end
    checks++;
    if (rsp_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got pending rsp=%0d wr=%0d exp 0", rsp_q.size(), wr_q.size());
      rsp_q.delete();
      wr_q.delete();
    end
  endtask

  // Issue one request; returns at the LOOKUP-cycle negedge.
  task automatic issue(input logic [AW-1:0] idx, input logic [DW-2:0] tag, output logic miss, output logic ok);
    int t = 0;
    @(negedge clock);
    while (!req_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    ok = req_ready;
    miss = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout got 0 exp 1");
    end else begin
      req_valid = 1'b1; req_index = idx; req_tag = tag;
      predict(idx, tag, cyc + 1, miss);
      @(negedge clock);
      req_valid = 1'b0;
    end
  endtask

  task automatic service_fill(input int ack_wait);
    int t = 0;
    while (!fill_req && t < 20) begin
      @(negedge clock);
      t++;
    end
    checks++;
    if (fill_req !== 1'b1) begin
      errors++;
      $display("FAIL fill_req_timeout got 0 exp 1");
    end else begin
      for (int i = 0; i < ack_wait; i++) begin
        @(negedge clock);
        checks++;
        if (fill_req !== 1'b1) begin
          errors++;
          $display("FAIL fill_req_hold got %0b exp 1", fill_req);
        end
      end
      fill_ack = 1'b1;
      @(negedge clock);
      fill_ack = 1'b0;
      checks++;
      if (fill_req !== 1'b0 || rsp_valid !== 1'b1) begin
        errors++;
        $display("FAIL miss_latency got fill_req=%0b rsp_valid=%0b exp 0/1", fill_req, rsp_valid);
      end
    end
  endtask

  task automatic do_req(input logic [AW-1:0] idx, input logic [DW-2:0] tag, input int ack_wait);
    logic miss, ok;
    issue(idx, tag, miss, ok);
    if (ok && miss) service_fill(ack_wait);
    drain();
  endtask

  task automatic apply_reset();
    int t = 0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    mlru = '0;
    rsp_q.delete();
    wr_q.delete();
`ifdef TAG_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      exp0[i] = '0;
      exp1[i] = '0;
    end
    clearing = 1'b1;
    reset = 1'b0;
    while (!req_ready && t < 40) begin
      t++;
      @(negedge clock);
    end
    clearing = 1'b0;
    checks++;
    if (t !== DEPTH) begin
      errors++;
      $display("FAIL clear_ready_low got=%0d exp=%0d", t, DEPTH);
    end
`else
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got=%0b exp=1", req_ready);
    end
`endif
  endtask

  task automatic test_reset();
    logic [5:0] ctl;
    for (int i = 0; i < DEPTH; i++) begin
      exp0[i] = ram0[i];
      exp1[i] = ram1[i];
    end
    repeat (3) @(negedge clock);
    ctl = {rsp_valid, rsp_hit, rsp_way, fill_req, t0_we, t1_we};
    checks++;
    if (ctl !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl got=%b exp=000000", ctl);
    end
    checks++;
    if ({t0_din, t1_din, t0_addr, t1_addr} !== '0) begin
      errors++;
      $display("FAIL reset_ram_bus got din0=%h din1=%h a0=%0d a1=%0d exp 0", t0_din, t1_din, t0_addr, t1_addr);
    end
    apply_reset();
  endtask

  task automatic test_hit();
    do_req(3'd2, 15'h0ABC, 1);
    do_req(3'd6, 15'h0007, 1);
    do_req(3'd2, 15'h0DEF, 1);
    do_req(3'd2, 15'h0ABC, 1);
    do_req(3'd2, 15'h0123, 2);
  endtask

  task automatic test_miss_lru();
    do_req(3'd5, 15'h0033, 0);
    do_req(3'd5, 15'h0044, 3);
    do_req(3'd5, 15'h0033, 0);
    do_req(3'd5, 15'h0055, 1);
  endtask

  task automatic test_invalid_first();
    do_req(3'd1, 15'h0005, 0);
    do_req(3'd1, 15'h0006, 1);
    do_req(3'd1, 15'h0006, 0);
  endtask

  task automatic test_back_to_back();
    logic miss;
    int n_acc = 0;
    logic [AW-1:0] idx_tab [4] = '{3'd5, 3'd1, 3'd5, 3'd1};
    logic [DW-2:0] tag_tab [4] = '{15'h0033, 15'h0006, 15'h0055, 15'h0006};
    @(negedge clock);
    req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clock);
      if (req_ready && n_acc < 4) begin
        req_index = idx_tab[n_acc];
        req_tag   = tag_tab[n_acc];
        predict(req_index, req_tag, cyc + 1, miss);
        n_acc++;
      end
    end
    @(negedge clock);
    req_valid = 1'b0;
    checks++;
    if (n_acc !== 4) begin
      errors++;
      $display("FAIL back_to_back_accepts got=%0d exp=4", n_acc);
    end
    drain();
  endtask

  task automatic test_ack_early();
    logic miss, ok;
    int rsp0, we0, nfill = 0;
    issue(3'd3, 15'h0077, miss, ok);
    #1;
    rsp0 = n_rsp; we0 = n_we;
    fill_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (i == 4) fill_ack = 1'b0;
      if (fill_req) nfill++;
    end
    #1;
    checks++;
    if (nfill !== 1 || n_rsp - rsp0 !== 1 || n_we - we0 !== 1) begin
      errors++;
      $display("FAIL ack_early got fill=%0d rsp=%0d we=%0d exp 1/1/1", nfill, n_rsp - rsp0, n_we - we0);
    end
    drain();
  endtask

  task automatic test_reset_miss();
    logic miss, ok;
    logic [DW-1:0] s0, s1;
    int rsp0, we0;
    s0 = exp0[4]; s1 = exp1[4];
    issue(3'd4, 15'h0999, miss, ok);
    @(negedge clock);
    checks++;
    if (fill_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_miss_setup got fill_req=%0b exp 1", fill_req);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (fill_req !== 1'b0 || t0_we !== 1'b0 || t1_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_miss got fill_req=%0b we0=%0b we1=%0b exp 0", fill_req, t0_we, t1_we);
    end
    exp0[4] = s0; exp1[4] = s1;
    apply_reset();
    #1;
    rsp0 = n_rsp; we0 = n_we;
    fill_ack = 1'b1;
    repeat (2) @(negedge clock);
    fill_ack = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (n_rsp !== rsp0 || n_we !== we0 || fill_req !== 1'b0) begin
      errors++;
      $display("FAIL late_ack got rsp=%0d we=%0d fill_req=%0b exp 0/0/0", n_rsp - rsp0, n_we - we0, fill_req);
    end
    do_req(3'd4, 15'h0999, 1);
    do_req(3'd5, 15'h0066, 0);
    do_req(3'd4, 15'h0999, 0);
  endtask

  initial begin
    mlru = '0;
    test_reset();
    test_hit();
    test_miss_lru();
    test_invalid_first();
    test_back_to_back();
    test_ack_early();
    test_reset_miss();
    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1, "watchdog");
  end
endmodule
